// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register address width, data width default and $0 index.
// Used by the register file, decode, hazard unit and writeback.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for long-latency producers: one busy flop per register,
// set on reserve, cleared by any write; REGFILE_BYPASS_EN masks same-cycle writes.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [NRD-1:0]        rd_busy,
  output logic                  busy_any
);

  logic [NREGS-1:0] busy;

  // Reserve is applied after the clears so a same-edge reserve keeps the register busy.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      busy <= '0;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_en[k]) busy[wr_addr[k*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (rsv_en && rsv_addr != '0) busy[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      rd_busy[j] = busy[rd_addr[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[j*ADDR_W +: ADDR_W])
          rd_busy[j] = 1'b0;
      end
`endif
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with hardwired $0, prioritised write ports and busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  localparam int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  busy_any
);

  logic [DATA_W-1:0] regs [NREGS];

  // Ports are visited in ascending order so the highest-index port wins a collision.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != '0)
          regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      rd_data[j*DATA_W +: DATA_W] = regs[rd_addr[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed during reset so reads stay zero while reset_in is high.
      for (int unsigned k = 0; k < NWR; k++) begin
        if (!reset_in && wr_en[k] && rd_addr[j*ADDR_W +: ADDR_W] != '0 &&
            wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[j*ADDR_W +: ADDR_W])
          rd_data[j*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
      end
`endif
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_busy  (rd_busy),
    .busy_any (busy_any)
  );

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Self-checking bench for mips_regfile_mp: directed scenarios plus randomized traffic on a
// 4-read/2-write and a 1-read/1-write instance against an array-based reference model.
module tb_mips_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   a_wen;
  logic [9:0]   a_wa;
  logic [63:0]  a_wd;
  logic [19:0]  a_ra;
  logic [127:0] a_rd;
  logic [3:0]   a_rb;
  logic         a_rsv;
  logic [4:0]   a_rsva;
  logic         a_any;

  logic [0:0]   b_wen;
  logic [4:0]   b_wa;
  logic [31:0]  b_wd;
  logic [4:0]   b_ra;
  logic [31:0]  b_rd;
  logic [0:0]   b_rb;
  logic         b_rsv;
  logic [4:0]   b_rsva;
  logic         b_any;

  mips_regfile_mp #(.DATA_W(32), .NREGS(32), .NRD(4), .NWR(2)) u_a (
    .clock_in(clk), .reset_in(rst), .wr_en(a_wen), .wr_addr(a_wa), .wr_data(a_wd),
    .rd_addr(a_ra), .rd_data(a_rd), .rd_busy(a_rb), .rsv_en(a_rsv), .rsv_addr(a_rsva),
    .busy_any(a_any)
  );

  mips_regfile_mp #(.DATA_W(32), .NREGS(32), .NRD(1), .NWR(1)) u_b (
    .clock_in(clk), .reset_in(rst), .wr_en(b_wen), .wr_addr(b_wa), .wr_data(b_wd),
    .rd_addr(b_ra), .rd_data(b_rd), .rd_busy(b_rb), .rsv_en(b_rsv), .rsv_addr(b_rsva),
    .busy_any(b_any)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural register values and outstanding-producer flags per DUT.
  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) begin
        m_reg[d][r]  = '0;
        m_busy[d][r] = 1'b0;
      end
  endtask

  task automatic model_edge(input int d, input logic [1:0] we, input logic [9:0] wa,
                            input logic [63:0] wd, input logic rsv, input logic [4:0] ra);
    for (int k = 0; k < 2; k++) begin
      if (we[k]) begin
        logic [4:0] a;
        a = wa[k*5 +: 5];
        m_busy[d][a] = 1'b0;
        if (a != 5'd0) m_reg[d][a] = wd[k*32 +: 32];
      end
    end
    if (rsv && ra != 5'd0) m_busy[d][ra] = 1'b1;
  endtask

  function automatic logic [31:0] exp_data(input int d, input logic [4:0] a, input logic [1:0] we,
                                           input logic [9:0] wa, input logic [63:0] wd);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_reg[d][a];
    for (int k = 0; k < 2; k++)
      if (BYPASS && !rst && we[k] && a != 5'd0 && wa[k*5 +: 5] == a) v = wd[k*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_busy(input int d, input logic [4:0] a, input logic [1:0] we,
                                    input logic [9:0] wa);
    logic b;
    b = (a == 5'd0) ? 1'b0 : m_busy[d][a];
    for (int k = 0; k < 2; k++)
      if (BYPASS && we[k] && wa[k*5 +: 5] == a) b = 1'b0;
    return b;
  endfunction

  function automatic logic exp_any(input int d);
    logic o;
    o = 1'b0;
    for (int r = 1; r < 32; r++) o = o | m_busy[d][r];
    return o;
  endfunction

  function automatic logic [4:0] pick();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
  endfunction

  task automatic idle();
    a_wen = '0; a_wa = '0; a_wd = '0; a_ra = '0; a_rsv = 1'b0; a_rsva = '0;
    b_wen = '0; b_wa = '0; b_wd = '0; b_ra = '0; b_rsv = 1'b0; b_rsva = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_edge(0, a_wen, a_wa, a_wd, a_rsv, a_rsva);
      model_edge(1, {1'b0, b_wen}, {5'd0, b_wa}, {32'd0, b_wd}, b_rsv, b_rsva);
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    rst = 1'b1;
    // Write presented while reset is held must be discarded.
    a_wen = 2'b01; a_wa[4:0] = 5'd9; a_wd[31:0] = 32'h1111_2222;
    tick();
    tick();
    n_vec++; if (a_rd !== 128'd0) begin n_err++; $display("FAIL reset_rd_a: got %h want 0", a_rd); end
    n_vec++; if (a_rb !== 4'd0) begin n_err++; $display("FAIL reset_busy_a: got %h want 0", a_rb); end
    n_vec++; if (a_any !== 1'b0) begin n_err++; $display("FAIL reset_any_a: got %b want 0", a_any); end
    n_vec++; if (b_rd !== 32'd0) begin n_err++; $display("FAIL reset_rd_b: got %h want 0", b_rd); end
    n_vec++; if (b_any !== 1'b0) begin n_err++; $display("FAIL reset_any_b: got %b want 0", b_any); end
    rst = 1'b0;
    idle();
    a_ra[4:0] = 5'd9;
    #1;
    n_vec++; if (a_rd[31:0] !== 32'd0) begin n_err++; $display("FAIL reset_discard: got %h want 0", a_rd[31:0]); end
    a_wen = 2'b01; a_wa[4:0] = 5'd5; a_wd[31:0] = 32'hDEAD_BEEF; a_rsv = 1'b1; a_rsva = 5'd6;
    tick();
    idle();
    a_ra[4:0] = 5'd5;
    #1;
    n_vec++; if (a_rd[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pre_reset_r5: got %h want deadbeef", a_rd[31:0]); end
    n_vec++; if (a_any !== 1'b1) begin n_err++; $display("FAIL pre_reset_any: got %b want 1", a_any); end
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++; if (a_rd[31:0] !== 32'd0) begin n_err++; $display("FAIL async_reset_r5: got %h want 0", a_rd[31:0]); end
    n_vec++; if (a_any !== 1'b0) begin n_err++; $display("FAIL async_reset_any: got %b want 0", a_any); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_zero();
    idle();
    a_wen = 2'b11; a_wd = {32'h1234_5678, 32'h1234_5678}; a_rsv = 1'b1; a_rsva = 5'd0;
    #1;
    n_vec++; if (a_rd[31:0] !== 32'd0) begin n_err++; $display("FAIL zero_same_cycle: got %h want 0", a_rd[31:0]); end
    tick();
    idle();
    #1;
    n_vec++; if (a_rd !== 128'd0) begin n_err++; $display("FAIL zero_read: got %h want 0", a_rd); end
    n_vec++; if (a_rb !== 4'd0) begin n_err++; $display("FAIL zero_busy: got %h want 0", a_rb); end
    n_vec++; if (a_any !== 1'b0) begin n_err++; $display("FAIL zero_any: got %b want 0", a_any); end
  endtask

  task automatic test_dual_write();
    idle();
    a_wen = 2'b11; a_wa = {5'd7, 5'd7}; a_wd = {32'h2, 32'h1};
    tick();
    idle();
    a_ra[4:0] = 5'd7;
    #1;
    n_vec++; if (a_rd[31:0] !== 32'h2) begin n_err++; $display("FAIL dual_priority: got %h want 2", a_rd[31:0]); end
    a_wen = 2'b11; a_wa = {5'd9, 5'd8}; a_wd = {32'hB, 32'hA};
    tick();
    idle();
    a_ra = {5'd0, 5'd0, 5'd9, 5'd8};
    #1;
    n_vec++; if (a_rd[31:0] !== 32'hA) begin n_err++; $display("FAIL dual_r8: got %h want a", a_rd[31:0]); end
    n_vec++; if (a_rd[63:32] !== 32'hB) begin n_err++; $display("FAIL dual_r9: got %h want b", a_rd[63:32]); end
  endtask

  task automatic test_bypass();
    idle();
    a_ra[4:0] = 5'd3;
    a_wen = 2'b01; a_wa[4:0] = 5'd3; a_wd[31:0] = 32'hCAFE;
    #1;
    n_vec++;
    if (a_rd[31:0] !== (BYPASS ? 32'hCAFE : 32'h0)) begin
      n_err++; $display("FAIL bypass_same: got %h want %h", a_rd[31:0], BYPASS ? 32'hCAFE : 32'h0);
    end
    tick();
    idle();
    a_ra[4:0] = 5'd3;
    #1;
    n_vec++; if (a_rd[31:0] !== 32'hCAFE) begin n_err++; $display("FAIL bypass_next: got %h want cafe", a_rd[31:0]); end
  endtask

  task automatic test_scoreboard();
    idle();
    a_rsv = 1'b1; a_rsva = 5'd4; a_ra[4:0] = 5'd4;
    #1;
    n_vec++; if (a_rb[0] !== 1'b0) begin n_err++; $display("FAIL sb_before: got %b want 0", a_rb[0]); end
    tick();
    idle();
    a_ra[4:0] = 5'd4;
    #1;
    n_vec++; if (a_rb[0] !== 1'b1) begin n_err++; $display("FAIL sb_set: got %b want 1", a_rb[0]); end
    n_vec++; if (a_any !== 1'b1) begin n_err++; $display("FAIL sb_any_set: got %b want 1", a_any); end
    a_wen = 2'b01; a_wa[4:0] = 5'd4; a_wd[31:0] = 32'h55;
    #1;
    n_vec++;
    if (a_rb[0] !== !BYPASS) begin n_err++; $display("FAIL sb_same_write: got %b want %b", a_rb[0], !BYPASS); end
    tick();
    idle();
    a_ra[4:0] = 5'd4;
    #1;
    n_vec++; if (a_rb[0] !== 1'b0) begin n_err++; $display("FAIL sb_clear: got %b want 0", a_rb[0]); end
    n_vec++; if (a_any !== 1'b0) begin n_err++; $display("FAIL sb_any_clear: got %b want 0", a_any); end
    n_vec++; if (a_rd[31:0] !== 32'h55) begin n_err++; $display("FAIL sb_data: got %h want 55", a_rd[31:0]); end
    a_wen = 2'b10; a_wa[9:5] = 5'd4; a_wd[63:32] = 32'h77; a_rsv = 1'b1; a_rsva = 5'd4;
    tick();
    idle();
    a_ra[4:0] = 5'd4;
    #1;
    n_vec++; if (a_rb[0] !== 1'b1) begin n_err++; $display("FAIL sb_rsv_wins: got %b want 1", a_rb[0]); end
    n_vec++; if (a_rd[31:0] !== 32'h77) begin n_err++; $display("FAIL sb_rsv_data: got %h want 77", a_rd[31:0]); end
    a_wen = 2'b01; a_wa[4:0] = 5'd4; a_wd[31:0] = 32'h77;
    tick();
    idle();
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      a_wen = 2'($urandom);
      for (int k = 0; k < 2; k++) a_wa[k*5 +: 5] = pick();
      a_wd = {$urandom, $urandom};
      for (int j = 0; j < 4; j++) a_ra[j*5 +: 5] = pick();
      a_rsv = ($urandom_range(0, 3) == 0);
      a_rsva = pick();
      b_wen = 1'($urandom);
      b_wa = pick();
      b_wd = $urandom;
      b_ra = pick();
      b_rsv = ($urandom_range(0, 3) == 0);
      b_rsva = pick();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      #1;
      for (int j = 0; j < 4; j++) begin
        n_vec++;
        if (a_rd[j*32 +: 32] !== exp_data(0, a_ra[j*5 +: 5], a_wen, a_wa, a_wd)) begin
          n_err++;
          $display("FAIL rand_rd_a[%0d] cyc %0d: got %h want %h", j, c, a_rd[j*32 +: 32],
                   exp_data(0, a_ra[j*5 +: 5], a_wen, a_wa, a_wd));
        end
        n_vec++;
        if (a_rb[j] !== exp_busy(0, a_ra[j*5 +: 5], a_wen, a_wa)) begin
          n_err++;
          $display("FAIL rand_busy_a[%0d] cyc %0d: got %b want %b", j, c, a_rb[j],
                   exp_busy(0, a_ra[j*5 +: 5], a_wen, a_wa));
        end
      end
      n_vec++;
      if (a_any !== exp_any(0)) begin
        n_err++; $display("FAIL rand_any_a cyc %0d: got %b want %b", c, a_any, exp_any(0));
      end
      n_vec++;
      if (b_rd !== exp_data(1, b_ra, {1'b0, b_wen}, {5'd0, b_wa}, {32'd0, b_wd})) begin
        n_err++;
        $display("FAIL rand_rd_b cyc %0d: got %h want %h", c, b_rd,
                 exp_data(1, b_ra, {1'b0, b_wen}, {5'd0, b_wa}, {32'd0, b_wd}));
      end
      n_vec++;
      if (b_rb[0] !== exp_busy(1, b_ra, {1'b0, b_wen}, {5'd0, b_wa})) begin
        n_err++;
        $display("FAIL rand_busy_b cyc %0d: got %b want %b", c, b_rb[0],
                 exp_busy(1, b_ra, {1'b0, b_wen}, {5'd0, b_wa}));
      end
      n_vec++;
      if (b_any !== exp_any(1)) begin
        n_err++; $display("FAIL rand_any_b cyc %0d: got %b want %b", c, b_any, exp_any(1));
      end
      tick();
      rst = 1'b0;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_random(10000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
